// File: rtl/dipsy_spi_cfg.sv
// dipsy_spi_cfg: SPI master that loads a bitstream into DIPSY (iCE40 UL1K) through its SPI-slave configuration port
// Ports: CLK/RST (synchronous, active-high); START/BUSY/DONE_OK/ERROR run control and sticky status;
//   S_DATA/S_VALID/S_LAST/S_READY bitstream byte input, MSB shifted first;
//   DIPSY_SCK/DIPSY_MOSI/DIPSY_SS/DIPSY_RESET drive the socket (SPI mode 3); DIPSY_DONE is CDONE (asynchronous).
// Build option: define DIPSY_CFG_DONE_TIMEOUT_EN to keep clocking in CHECK until CDONE rises or TIMEOUT_BITS cycles pass.
module dipsy_spi_cfg #(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 64,
  parameter int WAIT_CYCLES  = 60000,
  parameter int DUMMY_BITS   = 104,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE_OK,
  output logic       ERROR,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  input  logic       S_LAST,
  output logic       S_READY,
  output logic       DIPSY_SCK,
  output logic       DIPSY_MOSI,
  output logic       DIPSY_SS,
  output logic       DIPSY_RESET,
  input  logic       DIPSY_DONE
);
  localparam int CMAX = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BM1  = (DUMMY_BITS > 8) ? DUMMY_BITS : 8;
  localparam int BMAX = (TIMEOUT_BITS > BM1) ? TIMEOUT_BITS : BM1;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int PW   = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_END  = PW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] C_RST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] C_WAIT  = CW'(WAIT_CYCLES - 1);
  localparam logic [BW-1:0] B_BYTE  = BW'(7);
  localparam logic [BW-1:0] B_DUMMY = BW'(DUMMY_BITS - 1);
`ifdef DIPSY_CFG_DONE_TIMEOUT_EN
  localparam logic [BW-1:0] B_TO    = BW'(TIMEOUT_BITS);
`endif

  typedef enum logic [2:0] {IDLE, RST_LO, RST_WAIT, PRE, LOAD, POST, CHECK, FINISH} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cyc;
  logic [PW-1:0]   ph;
  logic [BW-1:0]   bcnt;
  logic [7:0]      shreg;
  logic            last, have, done_m, done_s;
  logic            chk_run, shifting, bit_end, hs;

  // CHECK only leaves at a bit boundary, so an extra SCK pulse is never cut short
`ifdef DIPSY_CFG_DONE_TIMEOUT_EN
  assign chk_run = (ph != '0) || (!done_s && bcnt != B_TO);
`else
  assign chk_run = 1'b0;
`endif

  assign shifting = state == PRE || state == POST || (state == LOAD && have) || (state == CHECK && chk_run);
  assign bit_end  = ph == PH_END;
  assign S_READY  = state == LOAD && !have;
  assign hs       = S_VALID && S_READY;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = START ? RST_LO : IDLE;
      RST_LO:   state_n = cyc == C_RST ? RST_WAIT : RST_LO;
      RST_WAIT: state_n = cyc == C_WAIT ? PRE : RST_WAIT;
      PRE:      state_n = bit_end && bcnt == B_BYTE ? LOAD : PRE;
      LOAD:     state_n = have && last && bit_end && bcnt == B_BYTE ? POST : LOAD;
      POST:     state_n = bit_end && bcnt == B_DUMMY ? CHECK : POST;
      CHECK:    state_n = chk_run ? CHECK : FINISH;
      default:  state_n = IDLE;
    endcase
  end

  // Socket pins are registered copies of the decoded state, so every pin lags by the same one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cyc         <= '0;
      ph          <= '0;
      bcnt        <= '0;
      shreg       <= '1;
      last        <= 1'b0;
      have        <= 1'b0;
      done_m      <= 1'b0;
      done_s      <= 1'b0;
      BUSY        <= 1'b0;
      DONE_OK     <= 1'b0;
      ERROR       <= 1'b0;
      DIPSY_SCK   <= 1'b1;
      DIPSY_MOSI  <= 1'b1;
      DIPSY_SS    <= 1'b1;
      DIPSY_RESET <= 1'b1;
    end else begin
      state       <= state_n;
      done_m      <= DIPSY_DONE;
      done_s      <= done_m;
      DIPSY_SCK   <= !(shifting && ph < PH_HI);
      DIPSY_MOSI  <= state != LOAD || shreg[7];
      DIPSY_SS    <= !(state == RST_LO || state == RST_WAIT || state == LOAD);
      DIPSY_RESET <= state != RST_LO;
      cyc         <= state_n != state ? '0 : (&cyc ? cyc : cyc + 1'b1);
      ph          <= (state_n != state || !shifting || bit_end) ? '0 : ph + 1'b1;
      bcnt        <= (state_n != state || hs) ? '0 : (shifting && bit_end && !(&bcnt) ? bcnt + 1'b1 : bcnt);
      shreg       <= hs ? S_DATA : (have && bit_end ? {shreg[6:0], 1'b1} : shreg);
      last        <= hs ? S_LAST : last;
      have        <= hs ? 1'b1 : (have && bit_end ? bcnt != B_BYTE : have);
      BUSY        <= state == IDLE && START ? 1'b1 : (state == FINISH ? 1'b0 : BUSY);
      DONE_OK     <= state == IDLE && START ? 1'b0 : (state == CHECK && !chk_run ? done_s : DONE_OK);
      ERROR       <= state == IDLE && START ? 1'b0 : (state == CHECK && !chk_run ? !done_s : ERROR);
    end
  end
endmodule

// File: tb/tb_dipsy_spi_cfg.sv
// tb_dipsy_spi_cfg: directed self-checking bench for dipsy_spi_cfg
module tb_dipsy_spi_cfg;
`ifdef DIPSY_CFG_DONE_TIMEOUT_EN
  localparam int ERR_POST = 16 + 1024;
`else
  localparam int ERR_POST = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, s_valid = 1'b0, s_last = 1'b0, dipsy_done = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       busy, done_ok, error, s_ready, sck, mosi, ss, creset;

  dipsy_spi_cfg #(
    .CLK_DIV(2), .RESET_CYCLES(4), .WAIT_CYCLES(16), .DUMMY_BITS(16), .TIMEOUT_BITS(1024)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE_OK(done_ok), .ERROR(error),
    .S_DATA(s_data), .S_VALID(s_valid), .S_LAST(s_last), .S_READY(s_ready),
    .DIPSY_SCK(sck), .DIPSY_MOSI(mosi), .DIPSY_SS(ss), .DIPSY_RESET(creset), .DIPSY_DONE(dipsy_done)
  );

  int total = 0, bad = 0;

  logic        clr = 1'b0, prev_sck = 1'b1, prev_rst = 1'b1;
  int          pre_r = 0, post_r = 0, rx_n = 0, rst_lo = 0, rst_pulses = 0, wait_c = 0, rises = 0;
  logic [15:0] rx_word = 16'h0;

  always @(negedge clk) begin
    prev_sck <= sck;
    prev_rst <= creset;
    if (clr) begin
      pre_r <= 0;
      post_r <= 0;
      rx_n <= 0;
      rst_lo <= 0;
      rst_pulses <= 0;
      wait_c <= 0;
      rises <= 0;
      rx_word <= 16'h0;
    end else begin
      if (!prev_sck && sck) begin
        rises <= rises + 1;
        if (!ss) begin
          rx_word <= {rx_word[14:0], mosi};
          rx_n <= rx_n + 1;
        end else if (rx_n == 0) pre_r <= pre_r + 1;
        else post_r <= post_r + 1;
      end
      if (!creset) rst_lo <= rst_lo + 1;
      if (prev_rst && !creset) rst_pulses <= rst_pulses + 1;
      if (creset && !ss && pre_r == 0 && rx_n == 0) wait_c <= wait_c + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", s_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    wait_ready();
    s_valid = 1'b1;
    s_data = b;
    s_last = l;
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("run_end", busy, 0);
  endtask

  task automatic check_pins_reset(input string tag);
    chk({tag, "_sck"}, sck, 1);
    chk({tag, "_mosi"}, mosi, 1);
    chk({tag, "_ss"}, ss, 1);
    chk({tag, "_reset"}, creset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_ok"}, done_ok, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_ready"}, s_ready, 0);
  endtask

  task automatic run_stream(input int gap, input bit dbl);
    int viol = 0;
    clear_mon();
    pulse_start();
    chk("busy_on", busy, 1);
    if (dbl) begin
      tick(10);
      pulse_start();
    end
    send_byte(8'hA5, 1'b0);
    if (gap > 0) begin
      wait_ready();
      repeat (gap) begin
        @(negedge clk);
        if (sck !== 1'b1 || ss !== 1'b0 || s_ready !== 1'b1) viol++;
      end
      chk("gap_hold", viol, 0);
    end
    send_byte(8'h3C, 1'b1);
    wait_idle(8000);
  endtask

  task automatic check_run(input int exp_post, input logic exp_ok);
    chk("reset_low_cycles", rst_lo, 4);
    chk("reset_pulses", rst_pulses, 1);
    chk("wait_cycles", wait_c, 16);
    chk("pre_pulses", pre_r, 8);
    chk("rx_bits", rx_n, 16);
    chk("rx_word", rx_word, 16'hA53C);
    chk("post_pulses", post_r, exp_post);
    chk("done_ok", done_ok, exp_ok);
    chk("error", error, !exp_ok);
  endtask

  initial begin
    int n;
    tick(3);
    rst = 1'b0;
    clear_mon();
    tick(50);
    check_pins_reset("idle");
    chk("idle_rises", rises, 0);

    run_stream(0, 1'b0);
    check_run(16, 1'b1);

    run_stream(20, 1'b0);
    check_run(16, 1'b1);

    run_stream(0, 1'b1);
    tick(30);
    check_run(16, 1'b1);
    chk("idle_after_double", busy, 0);

    dipsy_done = 1'b0;
    tick(4);
    run_stream(0, 1'b0);
    check_run(ERR_POST, 1'b0);

    dipsy_done = 1'b1;
    tick(4);
    clear_mon();
    pulse_start();
    send_byte(8'hA5, 1'b0);
    n = 0;
    while (rx_n < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_bits", rx_n, 3);
    rst = 1'b1;
    @(negedge clk);
    check_pins_reset("abort");
    rst = 1'b0;
    @(negedge clk);
    run_stream(0, 1'b0);
    check_run(16, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
